// File: rtl/imm_encode.sv
// Immediate encoder: range-checks a sign-extended immediate for the I/S/B/J format
// and scatters it into an instruction word through a 2-stage valid/ready pipeline.
module imm_encode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       imm_src,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             imm_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0]       FMT_I   = 2'b00;
  localparam logic [1:0]       FMT_S   = 2'b01;
  localparam logic [1:0]       FMT_B   = 2'b10;
  localparam logic [1:0]       FMT_J   = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Representable iff the bits above the format's sign bit all match it (B/J also need an even value).
  function automatic logic range_err(input logic [1:0] src, input logic [31:0] v);
    logic e;
    case (src)
      FMT_I, FMT_S: e = ~((&v[31:11]) | ~(|v[31:11]));
      FMT_B:        e = ~((&v[31:12]) | ~(|v[31:12])) | v[0];
      FMT_J:        e = ~((&v[31:20]) | ~(|v[31:20])) | v[0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  // Every immediate position of the format is overwritten, so no separate clear is needed.
  function automatic logic [31:0] encode(input logic [1:0] src, input logic [31:0] v,
                                         input logic [31:0] b);
    logic [31:0] w;
    w = b;
    case (src)
      FMT_I: w[31:20] = v[11:0];
      FMT_S: begin
        w[31:25] = v[11:5];
        w[11:7]  = v[4:0];
      end
      FMT_B: begin
        w[31]    = v[12];
        w[30:25] = v[10:5];
        w[11:8]  = v[4:1];
        w[7]     = v[11];
      end
      FMT_J: begin
        w[31]    = v[20];
        w[30:21] = v[10:1];
        w[20]    = v[11];
        w[19:12] = v[19:12];
      end
      default: w = b;
    endcase
    return w;
  endfunction

  logic        s1_valid_r;
  logic [1:0]  s1_src_r;
  logic [31:0] s1_imm_r;
  logic [31:0] s1_base_r;
  logic        s1_err_r;
  logic        s2_adv_s;
  logic        in_hs_s;
  logic        s1_mv_s;
  logic        out_hs_s;

  // Handshake and advance terms; in_ready depends combinationally on out_ready.
  always_comb begin
    s2_adv_s = ~out_valid | out_ready;
    in_ready = ~s1_valid_r | s2_adv_s;
    in_hs_s  = in_valid & in_ready;
    s1_mv_s  = s1_valid_r & s2_adv_s;
    out_hs_s = out_valid & out_ready;
  end

  // Stage 1: capture the beat and its range verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_src_r   <= 2'b00;
      s1_imm_r   <= 32'h0000_0000;
      s1_base_r  <= 32'h0000_0000;
      s1_err_r   <= 1'b0;
    end else if (in_hs_s) begin
      s1_valid_r <= 1'b1;
      s1_src_r   <= imm_src;
      s1_imm_r   <= imm;
      s1_base_r  <= base;
      s1_err_r   <= range_err(imm_src, imm);
    end else if (s1_mv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: encoded word; holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr     <= 32'h0000_0000;
      imm_err   <= 1'b0;
    end else if (s1_mv_s) begin
      out_valid <= 1'b1;
      instr     <= encode(s1_src_r, s1_imm_r, s1_base_r);
      imm_err   <= s1_err_r;
    end else if (out_hs_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Saturating statistics counters, counting the departing beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_count <= {CNT_W{1'b0}};
      err_count <= {CNT_W{1'b0}};
    end else if (out_hs_s) begin
      if (enc_count != CNT_MAX) enc_count <= enc_count + CNT_ONE;
      else                      enc_count <= enc_count;
      if (imm_err && (err_count != CNT_MAX)) err_count <= err_count + CNT_ONE;
      else                                   err_count <= err_count;
    end else begin
      enc_count <= enc_count;
      err_count <= err_count;
    end
  end

endmodule
